// File: rtl/memoria_instrucoes_prog_pkg.sv
// Shared definitions for the programmable instruction memory: instruction field
// layout, opcode constants, loader FSM states and the chunk-count helper.
package memoria_pkg;

    localparam logic [5:0] OPC_ADD  = 6'b000000;
    localparam logic [5:0] OPC_ADDI = 6'b010000;
    localparam logic [5:0] OPC_BNE  = 6'b001011;
    localparam logic [5:0] OPC_IN   = 6'b100000;
    localparam logic [5:0] OPC_OUT  = 6'b100010;
    localparam logic [5:0] OPC_JUMP = 6'b110000;

    localparam int OPC_MSB = 33;
    localparam int OPC_LSB = 28;
    localparam int RD_MSB  = 27;
    localparam int RD_LSB  = 22;
    localparam int RS_MSB  = 21;
    localparam int RS_LSB  = 16;
    localparam int RT_MSB  = 15;
    localparam int RT_LSB  = 10;
    localparam int IMM_MSB = 9;
    localparam int IMM_LSB = 0;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    // Number of programming chunks needed to cover one instruction word.
    function automatic int nch_calc(input int instr_w, input int chunk_w);
        return (instr_w + chunk_w - 1) / chunk_w;
    endfunction

endpackage

// File: rtl/memoria_instrucoes_prog_if.sv
// Fetch and programming bus of the instruction memory. The parity_err signal only
// exists when PARITY_CHECK_EN is defined.
interface memoria_instrucoes_prog_if #(
    parameter int INSTR_W = 34,
    parameter int ADDR_W  = 10,
    parameter int CHUNK_W = 8
);

    logic [ADDR_W-1:0]  read_address;
    logic [INSTR_W-1:0] Instrucao;
    logic               addr_fault;
    logic               fetch_stall;
    logic               prog_start;
    logic [ADDR_W:0]    prog_len;
    logic [CHUNK_W-1:0] prog_data;
    logic               prog_valid;
    logic               prog_ready;
    logic               prog_done;
    logic               prog_error;
`ifdef PARITY_CHECK_EN
    logic               parity_err;
`endif

    modport master (
`ifdef PARITY_CHECK_EN
        input  parity_err,
`endif
        output read_address, prog_start, prog_len, prog_data, prog_valid,
        input  Instrucao, addr_fault, fetch_stall, prog_ready, prog_done, prog_error
    );

    modport slave (
`ifdef PARITY_CHECK_EN
        output parity_err,
`endif
        input  read_address, prog_start, prog_len, prog_data, prog_valid,
        output Instrucao, addr_fault, fetch_stall, prog_ready, prog_done, prog_error
    );

endinterface

// File: rtl/memoria_word_asm.sv
// Assembles instruction words from little-endian programming chunks; word_ready
// marks the cycle in which the last chunk of a word is accepted.
module memoria_word_asm #(
    parameter int INSTR_W = 34,
    parameter int CHUNK_W = 8,
    parameter int NCH     = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clear,
    input  logic               chunk_valid,
    input  logic [CHUNK_W-1:0] chunk_data,
    output logic               word_ready,
    output logic [INSTR_W-1:0] word_out
);

    localparam int ASM_W = NCH * CHUNK_W;
    localparam int CNT_W = (NCH > 1) ? $clog2(NCH) : 1;

    logic [ASM_W-1:0] asm_reg;
    logic [ASM_W-1:0] asm_next;
    logic [CNT_W-1:0] chunk_cnt;

    // New chunks enter at the top so that chunk 0 ends up in the least significant bits.
    assign asm_next   = ASM_W'({chunk_data, asm_reg} >> CHUNK_W);
    assign word_out   = asm_next[INSTR_W-1:0];
    assign word_ready = chunk_valid && (chunk_cnt == CNT_W'(NCH - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            asm_reg   <= '0;
            chunk_cnt <= '0;
        end else if (clear) begin
            chunk_cnt <= '0;
        end else if (chunk_valid) begin
            asm_reg   <= asm_next;
            chunk_cnt <= word_ready ? '0 : chunk_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/memoria_instrucoes_prog.sv
// Run-time programmable instruction memory with registered fetch and a chunked
// loader port. Define PARITY_CHECK_EN to store and check an even-parity bit per word.
module memoria_instrucoes_prog
    import memoria_pkg::*;
#(
    parameter int                 INSTR_W  = 34,
    parameter int                 ADDR_W   = 10,
    parameter int                 DEPTH    = 64,
    parameter int                 CHUNK_W  = 8,
    parameter logic [INSTR_W-1:0] NOP_WORD = '0
) (
    input  logic                      clock,
    input  logic                      reset,
    memoria_instrucoes_prog_if.slave  bus
);

    localparam int              NCH     = nch_calc(INSTR_W, CHUNK_W);
    localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
`ifdef PARITY_CHECK_EN
    localparam int              MEM_W   = INSTR_W + 1;
`else
    localparam int              MEM_W   = INSTR_W;
`endif

    state_t             state;
    state_t             state_next;
    logic [ADDR_W:0]    word_cnt;
    logic [ADDR_W:0]    len_eff;
    logic               start_load;
    logic               chunk_accept;
    logic               word_ready;
    logic               last_word;
    logic [INSTR_W-1:0] asm_word;
    logic [MEM_W-1:0]   fetch_word;
    logic [MEM_W-1:0]   mem [DEPTH];

    assign start_load   = (state == IDLE) && bus.prog_start;
    assign chunk_accept = bus.prog_valid && bus.prog_ready;
    assign last_word    = word_ready && (word_cnt == len_eff - 1'b1);
    assign fetch_word   = mem[bus.read_address[IDX_W-1:0]];

    memoria_word_asm #(
        .INSTR_W (INSTR_W),
        .CHUNK_W (CHUNK_W),
        .NCH     (NCH)
    ) u_word_asm (
        .clock       (clock),
        .reset       (reset),
        .clear       (start_load),
        .chunk_valid (chunk_accept),
        .chunk_data  (bus.prog_data),
        .word_ready  (word_ready),
        .word_out    (asm_word)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next      = state;
        bus.prog_ready  = 1'b0;
        bus.fetch_stall = 1'b0;
        case (state)
            IDLE: begin
                if (bus.prog_start && (bus.prog_len != '0)) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                bus.prog_ready  = 1'b1;
                bus.fetch_stall = 1'b1;
                if (last_word) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Zero-length loads finish without leaving IDLE, so prog_done is a register
    // rather than a decode of the DONE state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            word_cnt       <= '0;
            len_eff        <= '0;
            bus.prog_done  <= 1'b0;
            bus.prog_error <= 1'b0;
        end else begin
            bus.prog_done <= 1'b0;
            if (start_load) begin
                word_cnt       <= '0;
                len_eff        <= (bus.prog_len > DEPTH_L) ? DEPTH_L : bus.prog_len;
                bus.prog_error <= (bus.prog_len > DEPTH_L);
                if (bus.prog_len == '0) begin
                    bus.prog_done <= 1'b1;
                end
            end
            if ((state == LOAD) && word_ready) begin
                word_cnt <= word_cnt + 1'b1;
                if (last_word) begin
                    bus.prog_done <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if ((state == LOAD) && word_ready) begin
`ifdef PARITY_CHECK_EN
            mem[word_cnt[IDX_W-1:0]] <= {^asm_word, asm_word};
`else
            mem[word_cnt[IDX_W-1:0]] <= asm_word;
`endif
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus.Instrucao  <= NOP_WORD;
            bus.addr_fault <= 1'b0;
`ifdef PARITY_CHECK_EN
            bus.parity_err <= 1'b0;
`endif
        end else if (state == LOAD) begin
            bus.Instrucao  <= NOP_WORD;
            bus.addr_fault <= 1'b0;
`ifdef PARITY_CHECK_EN
            bus.parity_err <= 1'b0;
`endif
        end else if ({1'b0, bus.read_address} >= DEPTH_L) begin
            bus.Instrucao  <= NOP_WORD;
            bus.addr_fault <= 1'b1;
`ifdef PARITY_CHECK_EN
            bus.parity_err <= 1'b0;
`endif
        end else begin
            bus.addr_fault <= 1'b0;
`ifdef PARITY_CHECK_EN
            if (^fetch_word) begin
                bus.Instrucao  <= NOP_WORD;
                bus.parity_err <= 1'b1;
            end else begin
                bus.Instrucao  <= fetch_word[INSTR_W-1:0];
                bus.parity_err <= 1'b0;
            end
`else
            bus.Instrucao  <= fetch_word;
`endif
        end
    end

endmodule
